// File: rtl/state_decoder_pkg.sv
// state_decoder_pkg: shared widths and 7-segment glyph constants.
// Segment order is {g,f,e,d,c,b,a}, bit0 = segment a, active-high (1 = lit).
package state_decoder_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg7_t;

  localparam seg7_t GLYPH_0     = 7'h3F;
  localparam seg7_t GLYPH_1     = 7'h06;
  localparam seg7_t GLYPH_2     = 7'h5B;
  localparam seg7_t GLYPH_3     = 7'h4F;
  localparam seg7_t GLYPH_4     = 7'h66;
  localparam seg7_t GLYPH_5     = 7'h6D;
  localparam seg7_t GLYPH_DASH  = 7'h40;
  localparam seg7_t GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational state-code -> active-high glyph lookup.
// Ports:
//   code  in  3      state code
//   glyph out SEG_W  active-high glyph (dash for invalid codes)
//   valid out 1      code < NUM_STATES
// Codes that are legal (NUM_STATES 7 or 8) but have no digit glyph show a dash.
module seg7_glyph_rom
  import state_decoder_pkg::*;
#(
  parameter int NUM_STATES = 6
) (
  input  logic [2:0] code,
  output seg7_t      glyph,
  output logic       valid
);

  always_comb begin
    valid = (int'(code) < NUM_STATES);
    glyph = GLYPH_DASH;
    if (valid) begin
      case (code)
        3'd0:    glyph = GLYPH_0;
        3'd1:    glyph = GLYPH_1;
        3'd2:    glyph = GLYPH_2;
        3'd3:    glyph = GLYPH_3;
        3'd4:    glyph = GLYPH_4;
        3'd5:    glyph = GLYPH_5;
        default: glyph = GLYPH_DASH;
      endcase
    end
  end

endmodule

// File: rtl/state_decoder.sv
// state_decoder: registered 3-bit FSM state -> 7-segment debug display.
// Ports:
//   i_clk      in   1      clock, rising edge
//   i_rst      in   1      synchronous active-high reset
//   i_state    in   3      state code, sampled every cycle
//   o_7seg     out  SEG_W  segment drive {g,f,e,d,c,b,a}
//   o_err      out  1      displayed code invalid (sticky when compiled in)
//   o_changed  out  1      one-cycle pulse when the registered code changes
// Macro STATE_DECODER_STICKY_ERR_EN: when defined, o_err latches on the first
// invalid code and only clears on i_rst.
// Latency is one cycle for all outputs.
module state_decoder
  import state_decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int NUM_STATES = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_state,
  output seg7_t      o_7seg,
  output logic       o_err,
  output logic       o_changed
);

  // Applied to every pattern, including blank, so reset blanks both polarities.
  localparam seg7_t POL_MASK = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  seg7_t      glyph;
  logic       valid;
  logic [2:0] prev_code;
  // Suppresses the change pulse on the first sample after reset, whatever it is.
  logic       primed;

  seg7_glyph_rom #(.NUM_STATES(NUM_STATES)) u_rom (
    .code  (i_state),
    .glyph (glyph),
    .valid (valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_7seg    <= GLYPH_BLANK ^ POL_MASK;
      o_err     <= 1'b0;
      o_changed <= 1'b0;
      prev_code <= 3'd0;
      primed    <= 1'b0;
    end else begin
      o_7seg    <= glyph ^ POL_MASK;
`ifdef STATE_DECODER_STICKY_ERR_EN
      o_err     <= o_err | ~valid;
`else
      o_err     <= ~valid;
`endif
      o_changed <= primed && (i_state != prev_code);
      prev_code <= i_state;
      primed    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_state_decoder.sv
// tb_state_decoder: directed scoreboard bench for state_decoder.
// Two instances share the stimulus: active-high (default) and ACTIVE_LOW=1.
module tb_state_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'd0;
  logic [6:0] seg_h, seg_l;
  logic       err_h, err_l, chg_h, chg_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [6:0] seg;
    logic       err;
    logic       chg;
  } exp_t;

  exp_t sb[$];

  // Independent reference state
  logic [2:0] m_prev = 3'd0;
  logic       m_primed = 1'b0;
  logic       m_err = 1'b0;

  state_decoder #(.ACTIVE_LOW(1'b0), .NUM_STATES(6)) dut_h (
    .i_clk(clk), .i_rst(rst), .i_state(state),
    .o_7seg(seg_h), .o_err(err_h), .o_changed(chg_h)
  );

  state_decoder #(.ACTIVE_LOW(1'b1), .NUM_STATES(6)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_state(state),
    .o_7seg(seg_l), .o_err(err_l), .o_changed(chg_l)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [2:0] s);
    logic [6:0] tbl [0:7];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h40, 7'h40};
    return tbl[s];
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [2:0] s);
    exp_t e;
    @(negedge clk);
    rst   = r;
    state = s;
    e.tag = tag;
    if (r) begin
      e.seg = 7'h00; e.err = 1'b0; e.chg = 1'b0;
      m_prev = 3'd0; m_primed = 1'b0; m_err = 1'b0;
    end else begin
      e.seg = ref_glyph(s);
`ifdef STATE_DECODER_STICKY_ERR_EN
      m_err = m_err | (s >= 3'd6);
`else
      m_err = (s >= 3'd6);
`endif
      e.err = m_err;
      e.chg = m_primed && (s != m_prev);
      m_prev = s; m_primed = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " seg"},    seg_h, e.seg);
      chk({e.tag, " seg_al"}, seg_l, ~e.seg);
      chk({e.tag, " err"},    {6'd0, err_h}, {6'd0, e.err});
      chk({e.tag, " err_al"}, {6'd0, err_l}, {6'd0, e.err});
      chk({e.tag, " chg"},    {6'd0, chg_h}, {6'd0, e.chg});
    end
  endtask

  initial begin
    // Reset for two cycles: blank display, no flags
    step("rst0", 1'b1, 3'd0);
    step("rst1", 1'b1, 3'd0);
    // Literal anchors independent of the model
    chk("rst_lit_h", seg_h, 7'h00);
    chk("rst_lit_l", seg_l, 7'h7F);

    // Sweep valid codes
    for (int i = 0; i < 6; i++) step($sformatf("sweep%0d", i), 1'b0, 3'(i));
    chk("sweep_lit5", seg_h, 7'h6D);

    // Invalid codes then recovery
    step("inv6", 1'b0, 3'd6);
    step("inv7", 1'b0, 3'd7);
    chk("inv_lit", seg_h, 7'h40);
    step("recov2", 1'b0, 3'd2);
    chk("recov_lit", seg_h, 7'h5B);

    // Hold: change pulse only on first cycle
    for (int i = 0; i < 4; i++) step($sformatf("hold%0d", i), 1'b0, 3'd3);

    // Wrap 7 -> 0
    step("pre_wrap", 1'b0, 3'd7);
    step("wrap0", 1'b0, 3'd0);
    chk("pol_lit_l", seg_l, 7'h40);

    // Mid-run reset clears everything, including sticky error
    step("pre_rst", 1'b0, 3'd5);
    step("mid_rst", 1'b1, 3'd5);
    // First non-zero sample after reset must not pulse
    step("post_rst", 1'b0, 3'd4);

    // Short random tail
    for (int i = 0; i < 20; i++) step($sformatf("rnd%0d", i), 1'b0, 3'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
